soc_system_sysid_ext: RTL



---
 rtl/sysid_pkg.sv | 39 +++
 rtl/sysid_uptime_ctr.sv | 39 +++
 rtl/soc_system_sysid_ext.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID slave: register offsets, the
// capability-word layout and the read pipeline beat type.
package sysid_pkg;

  // Word offsets of the fixed part of the register map
  localparam int unsigned OFS_ID        = 0;
  localparam int unsigned OFS_TS        = 1;
  localparam int unsigned OFS_SCRATCH   = 2;
  localparam int unsigned OFS_UP_LO     = 3;
  localparam int unsigned OFS_UP_HI     = 4;
  localparam int unsigned OFS_CAPS      = 5;
  localparam int unsigned OFS_USER_BASE = 8;

  // Register-map revision reported in CAPS[31:16]
  localparam logic [15:0] SYSID_VERSION = 16'h0002;

  // writedata bit that clears the uptime counter on a write to UPTIME_LO
  localparam int unsigned UPTIME_CLEAR = 0;

  // One stage of the read-return pipeline
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_beat_t;

  // CAPS layout: {VERSION, ADDR_W, READ_LATENCY, NUM_USER}
  function automatic logic [31:0] caps_word(input int unsigned num_user,
                                            input int unsigned rd_lat,
                                            input int unsigned addr_w);
    logic [31:0] nu;
    logic [31:0] rl;
    logic [31:0] aw;
    nu = num_user;
    rl = rd_lat;
    aw = addr_w;
    return {SYSID_VERSION, aw[3:0], rl[3:0], nu[7:0]};
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// 64-bit free-running uptime counter with synchronous clear, plus a
// high-word snapshot taken whenever the low word is read so software can
// assemble a tear-free 64-bit value from two 32-bit reads.
module sysid_uptime_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_snap
);

  logic [63:0] count;

  // Count every cycle; a clear makes the next value zero, counting resumes after
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + 64'd1;
    end
  end

  // Capture the high half of the same count whose low half is being read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_snap <= '0;
    end else if (snap) begin
      hi_snap <= count[63:32];
    end
  end

  assign lo = count[31:0];

endmodule

// File: rtl/soc_system_sysid_ext.sv
// Parametrised system-ID Avalon-MM slave: ID/timestamp words, byte-writable
// scratch, 64-bit uptime with high-word snapshot, capability word and a
// bank of user ID words. Reads return after READ_LATENCY cycles with a
// one-cycle readdatavalid pulse; there is no waitrequest.
module soc_system_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0001,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned NUM_USER     = 4,
  parameter logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] USER_WORDS = '0,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] CAPS = caps_word(NUM_USER, READ_LATENCY, ADDR_W);

  logic [31:0] word;
  logic        wr_acc;
  logic        up_clear;
  logic        up_snap;
  logic [31:0] up_lo;
  logic [31:0] up_hi_snap;
  logic [31:0] scratch;
  logic [31:0] rd_mux;
  rd_beat_t    stage1;

  assign word = 32'(address);

  // A read in the same cycle wins; the write (including an uptime clear) is dropped
  assign wr_acc   = write & ~read;
  assign up_clear = wr_acc && (word == OFS_UP_LO) && byteenable[0]
                    && writedata[UPTIME_CLEAR];
  assign up_snap  = read && (word == OFS_UP_LO);

  sysid_uptime_ctr u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (up_clear),
    .snap    (up_snap),
    .lo      (up_lo),
    .hi_snap (up_hi_snap)
  );

  // Scratch register: each enabled byte lane takes the written byte
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (wr_acc && (word == OFS_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Read data selected in the accept cycle; unmapped offsets return zero
  // NOTE: rd_mux is given a value before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (word)
      OFS_ID:      rd_mux = SYSTEM_ID;
      OFS_TS:      rd_mux = TIMESTAMP;
      OFS_SCRATCH: rd_mux = scratch;
      OFS_UP_LO:   rd_mux = up_lo;
      OFS_UP_HI:   rd_mux = up_hi_snap;
      OFS_CAPS:    rd_mux = CAPS;
      default: begin
        if ((NUM_USER > 0) && (word >= OFS_USER_BASE)
            && ((word - OFS_USER_BASE) < NUM_USER)) begin
          rd_mux = USER_WORDS[(word - OFS_USER_BASE)*32 +: 32];
        end
      end
    endcase
  end

  // First return stage: valid follows read, data only moves on an accepted read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1 <= '0;
    end else begin
      stage1.valid <= read;
      if (read) begin
        stage1.data <= rd_mux;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      rd_beat_t stage2;

      // Optional second return stage, holding data between valid beats
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stage2 <= '0;
        end else begin
          stage2.valid <= stage1.valid;
          if (stage1.valid) begin
            stage2.data <= stage1.data;
          end
        end
      end

      assign readdata      = stage2.data;
      assign readdatavalid = stage2.valid;
    end else begin : g_lat1
      assign readdata      = stage1.data;
      assign readdatavalid = stage1.valid;
    end
  endgenerate

endmodule
